rv_multicycle_ctrl: RTL and testbench
=====================================

Name: rv_multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32I integer core.
- Owns the PC and the instruction-fetch handshake.
- Decodes the OP, OPIMM, BRANCH, AUIPC, LUI, JALR and JAL major opcodes into ALU/register-file control for the shared datapath, one instruction at a time.
- Unsupported opcodes drive a sticky trap and halt the core.

Parameters:
RESET_PC  32'h0000_0000  PC value loaded on reset
XLEN      32             datapath width; only 32 is supported

Ports:
clk          in   1     core clock
reset        in   1     synchronous, active-high reset
imem_req     out  1     fetch request; held until accepted
imem_addr    out  32    fetch address (= pc)
imem_ack     in   1     fetch accepted; imem_rdata valid this cycle
imem_rdata   in   32    fetched instruction
rf_raddr1    out  5     rs1 index (instr[19:15])
rf_raddr2    out  5     rs2 index (instr[24:20])
rf_waddr     out  5     rd index (instr[11:7])
rf_we        out  1     register-file write enable; one-cycle pulse
alu_a_sel    out  1     0 = rs1, 1 = pc
alu_b_sel    out  1     0 = rs2, 1 = imm
alu_funct3   out  3     ALU operation select
alu_alt      out  1     SUB/SRA select (funct7 bit 5 qualified)
imm          out  32    sign-extended immediate for the current instruction
wb_sel       out  2     0 = alu result, 1 = pc+4, 2 = imm (LUI)
cmp_taken    in   1     branch compare result from datapath, valid in EXEC
alu_result   in   32    ALU output, valid in EXEC (JALR target source)
pc           out  32    current PC
trap         out  1     illegal instruction seen; sticky until reset

Behaviour:
- Reset values: pc = RESET_PC, state = FETCH. All other outputs are 0: imem_req, rf_we, trap, imm, selects.
- Reset wins over every other event. When reset is asserted mid-fetch, imem_req drops on the next edge and any late imem_ack is ignored.
- FETCH state:
  - imem_req = 1, imem_addr = pc.
  - On imem_ack, latch imem_rdata into instr and move to DECODE.
  - imem_req stays 1 with a stable address until ack; wait time is unbounded.
- DECODE state:
  - Drive rf_raddr1/2 from instr and compute imm.
  - Immediate formats: I for OPIMM/JALR, B for BRANCH, U for AUIPC/LUI, J for JAL.
  - Illegal instruction if any of:
    - instr[1:0] != 2'b11;
    - opcode[6:2] is outside the seven supported opcodes;
    - OP with funct7 not in {0000000, 0100000};
    - OP with 0100000 on a funct3 other than ADD_SUB or SRL_SRA;
    - OPIMM SLLI/SRLI_SRAI with an illegal funct7;
    - BRANCH with funct3 010 or 011.
  - Illegal -> TRAP, otherwise -> EXEC.
- EXEC state: controls held for one cycle.
  - OP: a = rs1, b = rs2, funct3 passthrough, alu_alt = instr[30].
  - OPIMM: b = imm; alu_alt = instr[30] only for SRLI_SRAI, else 0.
  - AUIPC: a = pc, b = imm, ADD.
  - JAL: a = pc, b = imm, ADD; target = alu_result.
  - JALR: a = rs1, b = imm, ADD; target = alu_result & ~1.
  - BRANCH: a = pc, b = imm, ADD; the datapath supplies cmp_taken from rs1/rs2.
  - Next state -> WB.
- WB state (exactly one cycle):
  - rf_we = 1 for all opcodes except BRANCH, and only when rd != 0.
  - wb_sel: OP/OPIMM/AUIPC = 0, JAL/JALR = 1, LUI = 2.
  - pc update:
    - JAL: target latched in EXEC.
    - JALR: masked target.
    - BRANCH: latched target if cmp_taken was 1 in EXEC, else pc+4.
    - All others: pc+4.
  - Next state -> FETCH.
- TRAP state:
  - trap = 1 and remains so; imem_req = 0; pc is frozen at the faulting instruction.
  - Only reset leaves TRAP.
- Timing:
  - Minimum 4 cycles per instruction with imem_ack asserted in the first FETCH cycle; each extra wait cycle adds one.
  - PC arithmetic is modulo 2^32 and wraps silently. Misaligned jump targets are not checked.

Decomposition:
- Shared instruction package holds:
  - the existing opcode/funct constants;
  - a new enum for the FSM states (FETCH, DECODE, EXEC, WB, TRAP);
  - constants for the wb_sel encodings.
- Immediate extraction goes in a sub-module, rv_imm_gen: combinational, instr in → imm out, opcode-selected format.

Test Plan:
- ADDI x1,x0,5 (0x00500093) with imem_ack on the first request cycle -> rf_we pulses in cycle 4 with waddr=1, wb_sel=0, b_sel=1, imm=5; pc goes 0->4.
- BEQ taken (cmp_taken=1, imm=-8, pc=0x10) -> no rf_we; pc=0x08. Same instruction with cmp_taken=0 -> pc=0x14.
- JALR x1,4(x2) with alu_result=0x0000_0103 -> rf_we with wb_sel=1; new pc=0x102.
- imem_ack delayed 3 cycles -> imem_req and imem_addr stable throughout; instruction latency is 7 cycles.
- OP with funct7=0000001, or opcode 0000011 -> trap=1 from the cycle after DECODE, imem_req stays 0, pc unchanged. Assert reset -> trap=0 and pc=RESET_PC on the next edge.
- ADD x0,x1,x2 -> rf_we stays 0. LUI x5,0x12345 -> imm=0x12345000, wb_sel=2.

Source files
------------

// File: rtl/rv_multicycle_ctrl_pkg.sv
// Shared RV32I instruction constants, sequencer state encoding and the
// illegal-instruction classifier used by the multi-cycle control unit.
package rv_multicycle_ctrl_pkg;

    // Major opcodes, instr[6:2]
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    // funct3 encodings that matter to decode
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_B_RSV0  = 3'b010;
    localparam logic [2:0] F3_B_RSV1  = 3'b011;

    // funct7 encodings
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Write-back source select
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_PC4 = 2'd1;
    localparam logic [1:0] WB_IMM = 2'd2;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        WB     = 3'd3,
        TRAP   = 3'd4
    } state_t;

    // True when the instruction is outside the supported RV32I subset
    function automatic logic is_illegal(input logic [6:0] opc7,
                                        input logic [2:0] f3,
                                        input logic [6:0] f7);
        logic ill;
        ill = 1'b0;
        if (opc7[1:0] != 2'b11) ill = 1'b1;
        case (opc7[6:2])
            OPC_OP: begin
                if (f7 != F7_BASE && f7 != F7_ALT) ill = 1'b1;
                if (f7 == F7_ALT && f3 != F3_ADD_SUB && f3 != F3_SRL_SRA) ill = 1'b1;
            end
            OPC_OPIMM: begin
                if (f3 == F3_SLL && f7 != F7_BASE) ill = 1'b1;
                if (f3 == F3_SRL_SRA && f7 != F7_BASE && f7 != F7_ALT) ill = 1'b1;
            end
            OPC_BRANCH: begin
                if (f3 == F3_B_RSV0 || f3 == F3_B_RSV1) ill = 1'b1;
            end
            OPC_AUIPC, OPC_LUI, OPC_JALR, OPC_JAL: ;
            default: ill = 1'b1;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Immediate extraction: picks the I/B/U/J format from the major opcode and
// returns the sign-extended 32-bit immediate; R-type and unknown give 0.
module rv_imm_gen
    import rv_multicycle_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    // The size bits instr[1:0] do not affect the immediate
    logic unused_size_bits;
    assign unused_size_bits = ^instr[1:0];

    // Format selection by major opcode
    always_comb begin
        imm = 32'd0;
        case (instr[6:2])
            OPC_OPIMM, OPC_JALR:
                imm = {{20{instr[31]}}, instr[31:20]};
            OPC_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_AUIPC, OPC_LUI:
                imm = {instr[31:12], 12'd0};
            OPC_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH -> DECODE -> EXEC -> WB, with a sticky
// TRAP state for unsupported encodings. Owns the PC and the fetch handshake.
module rv_multicycle_ctrl
    import rv_multicycle_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [4:0]      rf_raddr1,
    output logic [4:0]      rf_raddr2,
    output logic [4:0]      rf_waddr,
    output logic            rf_we,
    output logic            alu_a_sel,
    output logic            alu_b_sel,
    output logic [2:0]      alu_funct3,
    output logic            alu_alt,
    output logic [XLEN-1:0] imm,
    output logic [1:0]      wb_sel,
    input  logic            cmp_taken,
    input  logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] pc,
    output logic            trap
);

    state_t            state_q, state_d;
    logic [31:0]       instr_p1;
    logic [XLEN-1:0]   target_p2;
    logic              taken_p2;
    logic [XLEN-1:0]   pc_next;
    logic              req_en_q;
    logic [4:0]        opc;
    logic [2:0]        f3;

    assign opc       = instr_p1[6:2];
    assign f3        = instr_p1[14:12];
    assign imem_addr = pc;
    assign rf_raddr1 = instr_p1[19:15];
    assign rf_raddr2 = instr_p1[24:20];
    assign rf_waddr  = instr_p1[11:7];

    rv_imm_gen u_imm_gen (
        .instr (instr_p1),
        .imm   (imm)
    );

    // Control state, PC and latched instruction; req_en_q keeps the request
    // low for the first cycle after reset so a late ack cannot be taken
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FETCH;
            pc       <= RESET_PC;
            instr_p1 <= 32'd0;
            req_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_en_q <= 1'b1;
            if (state_q == FETCH && imem_req && imem_ack) instr_p1 <= imem_rdata;
            if (state_q == WB) pc <= pc_next;
        end
    end

    // EXEC stage: capture jump/branch target and branch outcome for WB
    always_ff @(posedge clk) begin
        if (state_q == EXEC) begin
            target_p2 <= (opc == OPC_JALR) ? {alu_result[XLEN-1:1], 1'b0} : alu_result;
            taken_p2  <= cmp_taken;
        end
    end

    // Next PC chosen in WB from the captured target or the fall-through
    always_comb begin
        pc_next = pc + XLEN'(4);
        case (opc)
            OPC_JAL, OPC_JALR: pc_next = target_p2;
            OPC_BRANCH:        if (taken_p2) pc_next = target_p2;
            default:           ;
        endcase
    end

    // Sequencer next state and per-state control outputs
    always_comb begin
        state_d    = state_q;
        imem_req   = 1'b0;
        rf_we      = 1'b0;
        alu_a_sel  = 1'b0;
        alu_b_sel  = 1'b0;
        alu_funct3 = F3_ADD_SUB;
        alu_alt    = 1'b0;
        wb_sel     = WB_ALU;
        trap       = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req = req_en_q;
                if (req_en_q && imem_ack) state_d = DECODE;
            end
            DECODE: begin
                state_d = is_illegal(instr_p1[6:0], f3, instr_p1[31:25]) ? TRAP : EXEC;
            end
            EXEC: begin
                case (opc)
                    OPC_OP: begin
                        alu_funct3 = f3;
                        alu_alt    = instr_p1[30];
                    end
                    OPC_OPIMM: begin
                        alu_b_sel  = 1'b1;
                        alu_funct3 = f3;
                        alu_alt    = (f3 == F3_SRL_SRA) && instr_p1[30];
                    end
                    OPC_AUIPC, OPC_JAL, OPC_BRANCH: begin
                        alu_a_sel = 1'b1;
                        alu_b_sel = 1'b1;
                    end
                    OPC_JALR: alu_b_sel = 1'b1;
                    default:  ;
                endcase
                state_d = WB;
            end
            WB: begin
                rf_we = (opc != OPC_BRANCH) && (rf_waddr != 5'd0);
                case (opc)
                    OPC_JAL, OPC_JALR: wb_sel = WB_PC4;
                    OPC_LUI:           wb_sel = WB_IMM;
                    default:           wb_sel = WB_ALU;
                endcase
                state_d = FETCH;
            end
            TRAP: trap = 1'b1;
            default: state_d = TRAP;
        endcase
    end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Scoreboard bench for rv_multicycle_ctrl: the driver pushes the expected
// per-instruction behaviour when it issues a fetch; a monitor pops it on each
// accepted fetch and walks DECODE/EXEC/WB comparing the control outputs.
module tb_rv_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [4:0]  rf_raddr1, rf_raddr2, rf_waddr;
    logic        rf_we, alu_a_sel, alu_b_sel, alu_alt;
    logic [2:0]  alu_funct3;
    logic [31:0] imm;
    logic [1:0]  wb_sel;
    logic        cmp_taken;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic        trap;

    always #5 clk = ~clk;

    rv_multicycle_ctrl #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_waddr(rf_waddr),
        .rf_we(rf_we), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .alu_funct3(alu_funct3), .alu_alt(alu_alt), .imm(imm), .wb_sel(wb_sel),
        .cmp_taken(cmp_taken), .alu_result(alu_result), .pc(pc), .trap(trap)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc0;
        logic        trap;
        logic        a_sel;
        logic        b_sel;
        logic [2:0]  f3;
        logic        alt;
        logic [31:0] imm;
        logic        we;
        logic [1:0]  wb;
        logic [31:0] pc1;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic busy     = 1'b0;
    logic pend     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc0,
                                input logic tr, input logic a, input logic b,
                                input logic [2:0] f3, input logic alt,
                                input logic [31:0] im, input logic we,
                                input logic [1:0] wb, input logic [31:0] pc1);
        exp_t e;
        e.instr = instr; e.pc0 = pc0; e.trap = tr; e.a_sel = a; e.b_sel = b;
        e.f3 = f3; e.alt = alt; e.imm = im; e.we = we; e.wb = wb; e.pc1 = pc1;
        return e;
    endfunction

    // Monitor: one accepted fetch -> DECODE, EXEC (or TRAP), WB, next-PC checks
    initial begin
        exp_t        e;
        logic [31:0] pend_pc;
        pend_pc = 32'd0;
        forever begin
            @(negedge clk);
            if (pend) begin
                chk("pc_after_wb", pc, pend_pc);
                pend = 1'b0;
            end
            if (!reset && imem_req && imem_ack) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_fetch: got addr 0x%08h, required no fetch", imem_addr);
                end else begin
                    e    = exp_q.pop_front();
                    busy = 1'b1;
                    chk("fetch_addr", imem_addr, e.pc0);
                    @(negedge clk);
                    chk("dec_imm", imm, e.imm);
                    chk("dec_raddr1", {27'd0, rf_raddr1}, {27'd0, e.instr[19:15]});
                    chk("dec_raddr2", {27'd0, rf_raddr2}, {27'd0, e.instr[24:20]});
                    chk("dec_no_trap", {31'd0, trap}, 32'd0);
                    @(negedge clk);
                    if (e.trap) begin
                        chk("trap_set", {31'd0, trap}, 32'd1);
                        chk("trap_req_low", {31'd0, imem_req}, 32'd0);
                        chk("trap_pc_frozen", pc, e.pc0);
                        @(negedge clk);
                        chk("trap_sticky", {31'd0, trap}, 32'd1);
                        chk("trap_pc_still", pc, e.pc0);
                    end else begin
                        chk("ex_a_sel", {31'd0, alu_a_sel}, {31'd0, e.a_sel});
                        chk("ex_b_sel", {31'd0, alu_b_sel}, {31'd0, e.b_sel});
                        chk("ex_funct3", {29'd0, alu_funct3}, {29'd0, e.f3});
                        chk("ex_alt", {31'd0, alu_alt}, {31'd0, e.alt});
                        chk("ex_no_we", {31'd0, rf_we}, 32'd0);
                        @(negedge clk);
                        chk("wb_we", {31'd0, rf_we}, {31'd0, e.we});
                        if (e.we) chk("wb_waddr", {27'd0, rf_waddr}, {27'd0, e.instr[11:7]});
                        chk("wb_sel", {30'd0, wb_sel}, {30'd0, e.wb});
                        pend    = 1'b1;
                        pend_pc = e.pc1;
                    end
                    busy = 1'b0;
                end
            end
        end
    end

    // Driver: issue one instruction with a given ack delay and datapath inputs
    task automatic run_instr(input exp_t e, input int waits, input logic cmp,
                             input logic [31:0] alu);
        int n;
        int t0;
        n = 0;
        cmp_taken  = cmp;
        alu_result = alu;
        while (!imem_req && n < 20) begin @(posedge clk); #1; n++; end
        if (!imem_req) begin
            n_checks++;
            n_fail++;
            $display("FAIL fetch_timeout: got no imem_req, required a fetch at 0x%08h", e.pc0);
            return;
        end
        exp_q.push_back(e);
        t0 = cyc;
        for (int k = 0; k < waits; k++) begin
            chk("req_hold", {31'd0, imem_req}, 32'd1);
            chk("addr_hold", imem_addr, e.pc0);
            @(posedge clk); #1;
        end
        imem_ack   = 1'b1;
        imem_rdata = e.instr;
        @(posedge clk); #1;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0000_0000;
        if (e.trap) begin
            repeat (4) @(posedge clk);
            #1;
        end else begin
            n = 0;
            while (!imem_req && n < 20) begin @(posedge clk); #1; n++; end
            chk("latency", cyc - t0, waits + 4);
        end
    endtask

    task automatic reset_and_check(input string tag);
        reset = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_trap"}, {31'd0, trap}, 32'd0);
        chk({tag, "_pc"}, pc, 32'h0000_0000);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        cmp_taken  = 1'b0;
        alu_result = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc, 32'h0000_0000);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_trap", {31'd0, trap}, 32'd0);
        chk("rst_we", {31'd0, rf_we}, 32'd0);
        chk("rst_imm", imm, 32'd0);
        chk("rst_wb_sel", {30'd0, wb_sel}, 32'd0);
        chk("rst_b_sel", {31'd0, alu_b_sel}, 32'd0);
        reset = 1'b0;

        // instr, pc0, trap, a, b, f3, alt, imm, we, wb, pc1
        run_instr(mk(32'h00500093, 32'h00, 0, 0, 1, 3'd0, 0, 32'd5,        1, 2'd0, 32'h04),  0, 1'b0, 32'd5);
        run_instr(mk(32'h123452B7, 32'h04, 0, 0, 0, 3'd0, 0, 32'h12345000, 1, 2'd2, 32'h08),  0, 1'b0, 32'd0);
        run_instr(mk(32'h00208033, 32'h08, 0, 0, 0, 3'd0, 0, 32'd0,        0, 2'd0, 32'h0C),  0, 1'b0, 32'd0);
        run_instr(mk(32'h402081B3, 32'h0C, 0, 0, 0, 3'd0, 1, 32'd0,        1, 2'd0, 32'h10),  3, 1'b0, 32'd0);
        run_instr(mk(32'hFE208CE3, 32'h10, 0, 1, 1, 3'd0, 0, 32'hFFFFFFF8, 0, 2'd0, 32'h08),  0, 1'b1, 32'h08);
        run_instr(mk(32'h00000013, 32'h08, 0, 0, 1, 3'd0, 0, 32'd0,        0, 2'd0, 32'h0C),  1, 1'b0, 32'd0);
        run_instr(mk(32'h4030D213, 32'h0C, 0, 0, 1, 3'd5, 1, 32'h403,      1, 2'd0, 32'h10),  0, 1'b0, 32'd0);
        run_instr(mk(32'hFE208CE3, 32'h10, 0, 1, 1, 3'd0, 0, 32'hFFFFFFF8, 0, 2'd0, 32'h14),  0, 1'b0, 32'h08);
        run_instr(mk(32'h004100E7, 32'h14, 0, 0, 1, 3'd0, 0, 32'd4,        1, 2'd1, 32'h102), 0, 1'b0, 32'h103);
        run_instr(mk(32'h0080006F, 32'h102, 0, 1, 1, 3'd0, 0, 32'd8,       0, 2'd1, 32'h10A), 2, 1'b0, 32'h10A);
        run_instr(mk(32'hFFFFF317, 32'h10A, 0, 1, 1, 3'd0, 0, 32'hFFFFF000, 1, 2'd0, 32'h10E), 0, 1'b0, 32'hFFFFF10A);
        run_instr(mk(32'h022080B3, 32'h10E, 1, 0, 0, 3'd0, 0, 32'd0,       0, 2'd0, 32'h10E), 0, 1'b0, 32'd0);
        reset_and_check("trap_reset1");

        // Reset asserted mid-fetch, then an ack arrives while the request is down
        n = 0;
        while (!imem_req && n < 20) begin @(posedge clk); #1; n++; end
        chk("midfetch_req_up", {31'd0, imem_req}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midfetch_req_drop", {31'd0, imem_req}, 32'd0);
        reset      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h00500093;
        @(posedge clk); #1;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        chk("late_ack_ignored_req", {31'd0, imem_req}, 32'd1);
        chk("late_ack_ignored_pc", pc, 32'h0000_0000);

        run_instr(mk(32'h00002083, 32'h00, 1, 0, 0, 3'd0, 0, 32'd0, 0, 2'd0, 32'h00), 0, 1'b0, 32'd0);
        reset_and_check("trap_reset2");

        n = 0;
        while ((exp_q.size() != 0 || busy || pend) && n < 50) begin @(posedge clk); n++; end
        if (exp_q.size() != 0 || busy || pend) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d queued, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
